// File: rtl/sort_frame_loader_pkg.sv
// Shared definitions for the frame loader: FSM states, sort direction and pad helper.
// Imported by the loader interface and the loader itself.
package sort_frame_loader_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_DEF          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } load_state_e;

  typedef enum logic {
    DIR_DESC = 1'b0,
    DIR_ASC  = 1'b1
  } sort_dir_e;

  // Pads must sort to the high lanes: all-ones when ascending, all-zeros when descending.
  function automatic logic pad_bit(input logic dir);
    return dir == DIR_ASC;
  endfunction

endpackage

// File: rtl/sort_frame_loader_if.sv
// Word-stream input and parallel-frame output of the loader, bundled as one interface.
// The loader connects through the slave modport; its driver/consumer uses master.
interface sort_frame_loader_if
  import sort_frame_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = N_DEF
);

  localparam int CW = $clog2(N) + 1;

  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_dir;
  logic                    in_ready;

  logic [N*DATA_WIDTH-1:0] frame_data;
  logic                    frame_dir;
  logic [CW-1:0]           frame_count;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (
    output in_data, in_valid, in_last, in_dir, frame_ready,
    input  in_ready, frame_data, frame_dir, frame_count, frame_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, in_dir, frame_ready,
    output in_ready, frame_data, frame_dir, frame_count, frame_valid
  );

endinterface

// File: rtl/sort_frame_loader.sv
// Serial-to-parallel loader feeding the CAE sorting network: collects up to N words,
// pads short frames by direction, and holds the frame until the sorter takes it.
module sort_frame_loader
  import sort_frame_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  sort_frame_loader_if.slave bus
);

  localparam int            CW         = $clog2(N) + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(N);

  load_state_e           state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] lane_q [N];
  logic [DATA_WIDTH-1:0] lane_d [N];

  logic [CW-1:0]         count_base;
  logic [CW-1:0]         count_next;
  logic                  dir_next;
  logic                  to_hold;
  logic                  pad_val;
  logic [N-1:0]          wr_en;
  logic [N-1:0]          pad_en;

  logic                  in_ready;
  logic                  frame_valid;
  logic                  in_xfer;
  logic                  out_xfer;

  assign in_ready    = en & rst & (state_q != ST_HOLD);
  assign frame_valid = en & (state_q == ST_HOLD);
  assign in_xfer     = bus.in_valid & in_ready;
  assign out_xfer    = frame_valid & bus.frame_ready;

  // The first word always lands in lane 0, whatever count the previous frame left behind.
  always_comb begin
    count_base = '0;
    dir_next   = dir_q;
    if (state_q != ST_IDLE) begin
      count_base = count_q;
    end else begin
      dir_next   = bus.in_dir;
    end
    count_next = count_base + CW'(1);
    to_hold    = bus.in_last | (count_next == COUNT_FULL);
    pad_val    = pad_bit(dir_next);
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign wr_en[k]  = in_xfer & (count_base == CW'(k));
    assign pad_en[k] = in_xfer & to_hold & (CW'(k) >= count_next);
    assign lane_d[k] = wr_en[k]  ? bus.in_data :
                       pad_en[k] ? {DATA_WIDTH{pad_val}} :
                                   lane_q[k];
    assign bus.frame_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (in_xfer) begin
          count_d = count_next;
          dir_d   = dir_next;
          state_d = to_hold ? ST_HOLD : ST_FILL;
        end
      end
      ST_HOLD: begin
        if (out_xfer) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      lane_q  <= lane_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_dir   = dir_q;
  assign bus.frame_count = count_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: constant frame table, hand-written corner
// sequences, and randomized frames checked against a lane-level reference model.
module tb_sort_frame_loader;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;
  localparam int FW = N * DW;

  typedef struct {
    int            nWords;
    logic          dir;
    logic          lastFlag;
    logic [FW-1:0] words;
    logic [CW-1:0] expCount;
    logic [FW-1:0] expFrame;
  } vec_t;

  logic clk;
  logic rst;
  logic en;

  int vecCount;
  int missCount;

  vec_t vecs [6];

  sort_frame_loader_if #(.DATA_WIDTH(DW), .N(N)) bus ();

  sort_frame_loader #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input int n, input logic d, input logic l,
                                 input logic [FW-1:0] w, input logic [CW-1:0] c,
                                 input logic [FW-1:0] f);
    vec_t v;
    v.nWords   = n;
    v.dir      = d;
    v.lastFlag = l;
    v.words    = w;
    v.expCount = c;
    v.expFrame = f;
    return v;
  endfunction

  // Reference: real words occupy the low lanes, every remaining lane holds the pad.
  function automatic logic [FW-1:0] refFrame(input logic [FW-1:0] words, input int n,
                                             input logic dir);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (k < n) r[k*DW +: DW] = words[k*DW +: DW];
      else       r[k*DW +: DW] = dir ? {DW{1'b1}} : {DW{1'b0}};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [FW-1:0] got,
                             input logic [FW-1:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the word was taken.
  task automatic pushWord(input logic [DW-1:0] d, input logic last, input logic dir,
                          output int waits);
    waits = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_dir   = dir;
    bus.in_valid = 1'b1;
    #1;
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 50) checkOutput("pushTimeout", 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Words startIdx..stopIdx-1 of a frame; in_dir is inverted after word 0 on purpose.
  task automatic applyStimulus(input logic [FW-1:0] words, input int startIdx,
                               input int stopIdx, input int total, input logic dir,
                               input logic last, input int gapMax, input logic chkReady);
    int waits;
    for (int k = startIdx; k < stopIdx; k++) begin
      pushWord(words[k*DW +: DW], last && (k == total - 1), (k == 0) ? dir : ~dir, waits);
      if (chkReady) checkOutput("readyWait", waits, 0);
      if (gapMax > 0) repeat ($urandom_range(gapMax, 0)) @(negedge clk);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [FW-1:0] expFrame,
                            input logic [CW-1:0] expCount, input logic expDir);
    #1;
    checkOutput({tag, ".valid"}, bus.frame_valid, 1'b1);
    checkOutput({tag, ".readyLow"}, bus.in_ready, 1'b0);
    checkOutput({tag, ".data"}, bus.frame_data, expFrame);
    checkOutput({tag, ".count"}, bus.frame_count, expCount);
    checkOutput({tag, ".dir"}, bus.frame_dir, expDir);
  endtask

  task automatic releaseFrame(input string tag);
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    #1;
    checkOutput({tag, ".validDrop"}, bus.frame_valid, 1'b0);
    checkOutput({tag, ".readyBack"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    logic [FW-1:0] w;
    logic [FW-1:0] exp;
    int            n;
    logic          d;
    logic          l;

    vecCount  = 0;
    missCount = 0;

    vecs[0] = mkVec(8, 1'b1, 1'b0,
                    {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 4'd8,
                    {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
    vecs[1] = mkVec(3, 1'b0, 1'b1, {160'h0, 32'd3, 32'd9, 32'd5}, 4'd3,
                    {{5{32'h0000_0000}}, 32'd3, 32'd9, 32'd5});
    vecs[2] = mkVec(3, 1'b1, 1'b1, {160'h0, 32'd3, 32'd9, 32'd5}, 4'd3,
                    {{5{32'hFFFF_FFFF}}, 32'd3, 32'd9, 32'd5});
    vecs[3] = mkVec(1, 1'b1, 1'b1, {224'h0, 32'hA5A5_0001}, 4'd1,
                    {{7{32'hFFFF_FFFF}}, 32'hA5A5_0001});
    vecs[4] = mkVec(8, 1'b1, 1'b1,
                    {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10}, 4'd8,
                    {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10});
    vecs[5] = mkVec(7, 1'b0, 1'b1,
                    {32'h0, 32'hDEAD_0006, 32'hDEAD_0005, 32'hDEAD_0004, 32'hDEAD_0003,
                     32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 4'd7,
                    {32'h0, 32'hDEAD_0006, 32'hDEAD_0005, 32'hDEAD_0004, 32'hDEAD_0003,
                     32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000});

    rst             = 1'b0;
    en              = 1'b1;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_dir      = 1'b0;
    bus.frame_ready = 1'b0;

    #3;
    checkOutput("rst.inReady", bus.in_ready, 1'b0);
    checkOutput("rst.frameValid", bus.frame_valid, 1'b0);
    checkOutput("rst.frameData", bus.frame_data, '0);
    checkOutput("rst.frameCount", bus.frame_count, '0);
    checkOutput("rst.frameDir", bus.frame_dir, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst.readyAfter", bus.in_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].words, 0, vecs[i].nWords, vecs[i].nWords, vecs[i].dir,
                    vecs[i].lastFlag, 0, 1'b1);
      checkFrame($sformatf("vec%0d", i), vecs[i].expFrame, vecs[i].expCount, vecs[i].dir);
      releaseFrame($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Backpressure: the held frame must ignore new input for ten cycles.
    for (int k = 0; k < N; k++) w[k*DW +: DW] = $urandom;
    applyStimulus(w, 0, N, N, 1'b0, 1'b0, 0, 1'b0);
    checkFrame("bp", w, 4'd8, 1'b0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_data = $urandom;
      @(negedge clk);
      #1;
      checkOutput("bp.readyLow", bus.in_ready, 1'b0);
      checkOutput("bp.stable", bus.frame_data, w);
      checkOutput("bp.validHeld", bus.frame_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    releaseFrame("bp");
    @(negedge clk);

    // Enable dropped mid-fill, then again during hold.
    for (int k = 0; k < N; k++) w[k*DW +: DW] = 32'h200 + k;
    applyStimulus(w, 0, 4, N, 1'b1, 1'b0, 0, 1'b0);
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("enFill.readyLow", bus.in_ready, 1'b0);
      checkOutput("enFill.validLow", bus.frame_valid, 1'b0);
      @(negedge clk);
    end
    en           = 1'b1;
    bus.in_valid = 1'b0;
    applyStimulus(w, 4, N, N, 1'b1, 1'b0, 0, 1'b0);
    checkFrame("enFill", w, 4'd8, 1'b1);
    en              = 1'b0;
    bus.frame_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("enHold.validLow", bus.frame_valid, 1'b0);
      checkOutput("enHold.readyLow", bus.in_ready, 1'b0);
      checkOutput("enHold.data", bus.frame_data, w);
      @(negedge clk);
    end
    bus.frame_ready = 1'b0;
    en              = 1'b1;
    #1;
    checkOutput("enHold.resume", bus.frame_valid, 1'b1);
    releaseFrame("enHold");
    @(negedge clk);

    // Asynchronous reset between edges after five words.
    for (int k = 0; k < N; k++) w[k*DW +: DW] = 32'h300 + k;
    applyStimulus(w, 0, 5, N, 1'b1, 1'b0, 0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst.count", bus.frame_count, '0);
    checkOutput("arst.data", bus.frame_data, '0);
    checkOutput("arst.dir", bus.frame_dir, 1'b0);
    checkOutput("arst.readyLow", bus.in_ready, 1'b0);
    checkOutput("arst.validLow", bus.frame_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N; k++) w[k*DW +: DW] = 32'h400 + k;
    applyStimulus(w, 0, N, N, 1'b0, 1'b0, 0, 1'b0);
    checkFrame("arst.clean", w, 4'd8, 1'b0);
    releaseFrame("arst");
    @(negedge clk);

    // Randomized frames: random length, direction, gaps and hold time.
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(N, 1);
      d = 1'($urandom_range(1, 0));
      l = (n < N) ? 1'b1 : 1'($urandom_range(1, 0));
      w = '0;
      for (int k = 0; k < N; k++) w[k*DW +: DW] = $urandom;
      exp = refFrame(w, n, d);
      applyStimulus(w, 0, n, n, d, l, 2, 1'b0);
      checkFrame($sformatf("rnd%0d", f), exp, CW'(n), d);
      repeat ($urandom_range(3, 0)) begin
        @(negedge clk);
        #1;
        checkOutput("rnd.holdData", bus.frame_data, exp);
      end
      releaseFrame($sformatf("rnd%0d", f));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
